// File: rtl/rv_fetch.sv
// rv_fetch: instruction fetch unit, the initiator side of the instruction memory.
// Issues sequential word fetches under a credit limit, remembers the PC of
// every in-flight request, buffers returned {pc, instr} pairs in a prefetch
// FIFO and hands them to decode over valid/ready. A redirect flushes the FIFO
// and marks every request still in flight as stale so its response is dropped.
module rv_fetch #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 4,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // instruction memory request/response
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_rvalid_i,
    input  logic [XLEN-1:0] instr_rdata_i,
    // control-flow redirect
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    // decode handshake
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] fetch_instr_o,
    output logic [XLEN-1:0] fetch_pc_o
);

    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_AW + 1;
    localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned TAG_AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SUM_W   = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    localparam logic [FIFO_AW-1:0] FIFO_LAST = FIFO_AW'(FIFO_DEPTH - 1);
    localparam logic [TAG_AW-1:0]  TAG_LAST  = TAG_AW'(MAX_OUTSTANDING - 1);

    // Registered state
    logic [XLEN-1:0]    pc_q,          pc_d;
    logic [FIFO_AW-1:0] fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [FIFO_AW-1:0] fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [CNT_W-1:0]   fifo_count_q,  fifo_count_d;
    logic [TAG_AW-1:0]  tag_wr_ptr_q,  tag_wr_ptr_d;
    logic [TAG_AW-1:0]  tag_rd_ptr_q,  tag_rd_ptr_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [OUT_W-1:0]   discard_q,     discard_d;

    // Storage arrays (written only through their enables below)
    logic [XLEN-1:0] tag_pc_q     [MAX_OUTSTANDING];
    logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_instr_q [FIFO_DEPTH];

    // Per-cycle events
    logic             issue;
    logic             rsp_take;
    logic             rsp_drop;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_valid;
    logic [SUM_W-1:0] credit_used;

    // Redirect targets are word aligned; the two low bits are deliberately ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    function automatic logic [FIFO_AW-1:0] fifo_inc(input logic [FIFO_AW-1:0] ptr);
        return (ptr == FIFO_LAST) ? '0 : ptr + FIFO_AW'(1);
    endfunction

    function automatic logic [TAG_AW-1:0] tag_inc(input logic [TAG_AW-1:0] ptr);
        return (ptr == TAG_LAST) ? '0 : ptr + TAG_AW'(1);
    endfunction

    // Credit: every issued request already owns a FIFO slot, so a response can
    // always be stored and the memory never needs to be stalled.
    assign credit_used = SUM_W'(fifo_count_q) + SUM_W'(outstanding_q);

    assign issue = !rst_i && !redirect_i
                   && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                   && (credit_used < SUM_W'(FIFO_DEPTH));

    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp_take   = instr_rvalid_i && (outstanding_q != '0);
    assign rsp_drop   = rsp_take && (discard_q != '0);
    assign fifo_valid = !rst_i && (fifo_count_q != '0);
    assign fifo_push  = rsp_take && !rsp_drop && !redirect_i;
    assign fifo_pop   = fifo_valid && fetch_ready_i && !redirect_i;

    // Outputs; the head is zeroed while the FIFO is empty so stale slots never show.
    assign instr_req_o   = issue;
    assign instr_addr_o  = pc_q;
    assign fetch_valid_o = fifo_valid;
    assign fetch_instr_o = fifo_valid ? fifo_instr_q[fifo_rd_ptr_q] : '0;
    assign fetch_pc_o    = fifo_valid ? fifo_pc_q[fifo_rd_ptr_q]    : '0;

    // Next-state logic for PC, in-flight tracking, stale-response discard and FIFO pointers.
    always_comb begin
        // NOTE: every _d starts from its _q value so no path through this block infers a latch.
        pc_d          = pc_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_count_d  = fifo_count_q;
        tag_wr_ptr_d  = tag_wr_ptr_q;
        tag_rd_ptr_d  = tag_rd_ptr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        // Fetch PC: redirect wins, otherwise advance one word per issued request.
        if (redirect_i) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + XLEN'(4);
        end

        // In-flight tag queue: push PC on issue, pop on any accepted response.
        if (issue) begin
            tag_wr_ptr_d = tag_inc(tag_wr_ptr_q);
        end
        if (rsp_take) begin
            tag_rd_ptr_d = tag_inc(tag_rd_ptr_q);
        end

        unique case ({issue, rsp_take})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // Every request still in flight after a redirect edge belongs to the old stream.
        if (redirect_i) begin
            discard_d = outstanding_d;
        end else if (rsp_drop) begin
            discard_d = discard_q - OUT_W'(1);
        end

        // Prefetch FIFO: a redirect voids any same-cycle push or pop.
        if (redirect_i) begin
            fifo_wr_ptr_d = '0;
            fifo_rd_ptr_d = '0;
            fifo_count_d  = '0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr_d = fifo_inc(fifo_wr_ptr_q);
            end
            if (fifo_pop) begin
                fifo_rd_ptr_d = fifo_inc(fifo_rd_ptr_q);
            end
            fifo_count_d = fifo_count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            pc_q          <= RESET_PC;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_count_q  <= '0;
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            tag_wr_ptr_q  <= tag_wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Tag and FIFO payload storage, written on issue and on push.
    always_ff @(posedge clk_i) begin
        // NOTE: payload arrays are not reset; the counts and pointers alone decide what is valid.
        if (issue) begin
            tag_pc_q[tag_wr_ptr_q] <= pc_q;
        end
        if (fifo_push) begin
            fifo_pc_q[fifo_wr_ptr_q]    <= tag_pc_q[tag_rd_ptr_q];
            fifo_instr_q[fifo_wr_ptr_q] <= instr_rdata_i;
        end
    end

endmodule
